// File: rtl/console_rx_pkg.sv
// Shared console-link definitions: symbol codes, default sizes and the
// receiver state type. The cpu transmit logic uses the same symbol codes.
package console_rx_pkg;

    localparam int CON_CWIDTH = 7;
    localparam int CON_DEPTH  = 16;

    localparam logic [CON_CWIDTH-1:0] CON_IDLE_SYM  = 7'h7F;
    localparam logic [CON_CWIDTH-1:0] CON_START_SYM = 7'h00;

    typedef enum logic {
        RX_IDLE,
        RX_MSG
    } rx_state_t;

    // True for a symbol that carries a character, not link framing.
    function automatic logic con_is_data(input logic [CON_CWIDTH-1:0] sym);
        return (sym != CON_IDLE_SYM) && (sym != CON_START_SYM);
    endfunction

endpackage

// File: rtl/console_rx_if.sv
// Console receive bus: the symbol stream coming in and the valid/ready
// character stream going out, plus status.
interface console_rx_if
    import console_rx_pkg::*;
#(
    parameter int CWIDTH = CON_CWIDTH
);
    logic [CWIDTH-1:0] rx;
    logic              out_valid;
    logic              out_ready;
    logic [CWIDTH-1:0] out_char;
    logic              out_last;
    logic [15:0]       msg_count;
    logic              ovf;
    logic              frm_err;

    // Side that drives the symbol stream and consumes characters.
    modport master (
        output rx, out_ready,
        input  out_valid, out_char, out_last, msg_count, ovf, frm_err
    );

    // The receiver itself.
    modport slave (
        input  rx, out_ready,
        output out_valid, out_char, out_last, msg_count, ovf, frm_err
    );
endinterface

// File: rtl/console_rx_char_fifo.sv
// Synchronous FIFO for received characters. Head is read straight from the
// storage registers, so a write into an empty FIFO shows up the next cycle
// (no fall-through). Pointers carry one extra wrap bit to tell full from empty.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO only lands if the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer and storage values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/console_rx.sv
// Console link receiver: frames the per-cycle symbol stream into messages,
// holds one character back in a stage register so the final character of a
// message can be tagged when the terminating idle symbol arrives, and queues
// tagged characters for a valid/ready consumer.
module console_rx
    import console_rx_pkg::*;
#(
    parameter int                DEPTH     = CON_DEPTH,
    parameter int                CWIDTH    = CON_CWIDTH,
    parameter logic [CWIDTH-1:0] IDLE_SYM  = CON_IDLE_SYM,
    parameter logic [CWIDTH-1:0] START_SYM = CON_START_SYM
) (
    input  logic         clk,
    input  logic         reset,
    console_rx_if.slave  bus
);
    rx_state_t         state_q, state_d;
    logic              stg_v_q, stg_v_d;
    logic [CWIDTH-1:0] stg_c_q, stg_c_d;
    logic [15:0]       msg_count_q, msg_count_d;
    logic              ovf_q, ovf_d;
    logic              frm_err_q, frm_err_d;

    logic              push, pop;
    logic [CWIDTH:0]   push_data;
    logic [CWIDTH:0]   fifo_dout;
    logic              fifo_empty, fifo_full;

    assign pop = !fifo_empty && bus.out_ready;

    // Framing FSM and stage register: decide what to push and what to flag.
    always_comb begin
        state_d     = state_q;
        stg_v_d     = stg_v_q;
        stg_c_d     = stg_c_q;
        msg_count_d = msg_count_q;
        frm_err_d   = 1'b0;
        push        = 1'b0;
        push_data   = {1'b0, stg_c_q};
        unique case (state_q)
            RX_IDLE: begin
                if (bus.rx == START_SYM) begin
                    state_d = RX_MSG;
                    stg_v_d = 1'b0;
                end else if (bus.rx != IDLE_SYM) begin
                    frm_err_d = 1'b1;
                end
            end
            RX_MSG: begin
                if (bus.rx == IDLE_SYM) begin
                    // End of message: the held char is the last one. An empty
                    // message pushes and counts nothing.
                    if (stg_v_q) begin
                        push        = 1'b1;
                        push_data   = {1'b1, stg_c_q};
                        msg_count_d = msg_count_q + 16'd1;
                    end
                    stg_v_d = 1'b0;
                    state_d = RX_IDLE;
                end else if (bus.rx == START_SYM) begin
                    // Restart inside a message: drop the partial stage.
                    frm_err_d = 1'b1;
                    stg_v_d   = 1'b0;
                end else begin
                    push    = stg_v_q;
                    stg_c_d = bus.rx;
                    stg_v_d = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        ovf_d = ovf_q || (push && fifo_full && !pop);
    end

    // State, stage, counter and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            stg_v_q     <= 1'b0;
            stg_c_q     <= '0;
            msg_count_q <= '0;
            ovf_q       <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stg_v_q     <= stg_v_d;
            stg_c_q     <= stg_c_d;
            msg_count_q <= msg_count_d;
            ovf_q       <= ovf_d;
            frm_err_q   <= frm_err_d;
        end
    end

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CWIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Head fields are forced to zero when nothing is queued.
    assign bus.out_valid = !fifo_empty;
    assign bus.out_char  = fifo_empty ? '0 : fifo_dout[CWIDTH-1:0];
    assign bus.out_last  = !fifo_empty && fifo_dout[CWIDTH];
    assign bus.msg_count = msg_count_q;
    assign bus.ovf       = ovf_q;
    assign bus.frm_err   = frm_err_q;

endmodule

// File: tb/tb_console_rx.sv
// Bench for console_rx: a vector table for framing/counting behaviour, plus
// hand-written sequences for overflow, full push+pop and mid-message reset.
// Received characters are checked against a scoreboard queue.
module tb_console_rx;
    import console_rx_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    console_rx_if #(.CWIDTH(7)) bus ();

    console_rx #(.DEPTH(16), .CWIDTH(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0] c;
        logic       l;
    } exp_t;

    typedef struct {
        logic [6:0]  rx;
        logic        sb_en;
        logic        sb_last;
        logic        exp_frm;
        logic [15:0] exp_cnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[19];
    int   nchk  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] rx, input logic sb_en, input logic sb_last,
                                input logic frm, input logic [15:0] cnt);
        vec_t v;
        v.rx = rx; v.sb_en = sb_en; v.sb_last = sb_last; v.exp_frm = frm; v.exp_cnt = cnt;
        return v;
    endfunction

    // Drive one symbol, then advance to just after the edge that samples it.
    task automatic cyc(input logic [6:0] rx, input logic rdy);
        bus.rx        = rx;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_char(input logic [6:0] c, input logic l);
        exp_t e;
        e.c = c; e.l = l;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) cyc(CON_IDLE_SYM, 1'b1);
        cyc(CON_IDLE_SYM, 1'b1);
        cyc(CON_IDLE_SYM, 1'b1);
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_out_valid", bus.out_valid, 0);
    endtask

    // Consumer side: compare every accepted char, and require the head to
    // hold still while it is stalled.
    logic       hold = 1'b0;
    logic [6:0] hold_c;
    logic       hold_l;
    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_char", bus.out_char, hold_c);
                chk("hold_last", bus.out_last, hold_l);
            end
            if (bus.out_valid && bus.out_ready) begin
                nchk++;
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_char: got %0h last %0b, expected none", bus.out_char, bus.out_last);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_char", bus.out_char, e.c);
                    chk("out_last", bus.out_last, e.l);
                end
            end
            hold   = bus.out_valid && !bus.out_ready;
            hold_c = bus.out_char;
            hold_l = bus.out_last;
        end
    end

    initial begin
        // Framing / counting vectors, out_ready held high.
        vecs[0]  = mk(7'h7F, 0, 0, 0, 0);
        vecs[1]  = mk(7'h00, 0, 0, 0, 0);
        vecs[2]  = mk("H",   1, 0, 0, 0);
        vecs[3]  = mk("i",   1, 1, 0, 0);
        vecs[4]  = mk(7'h7F, 0, 0, 0, 1);
        vecs[5]  = mk(7'h00, 0, 0, 0, 1);   // empty message
        vecs[6]  = mk(7'h7F, 0, 0, 0, 1);
        vecs[7]  = mk(7'h7F, 0, 0, 0, 1);
        vecs[8]  = mk(7'h7F, 0, 0, 0, 1);
        vecs[9]  = mk(7'h7F, 0, 0, 0, 1);
        vecs[10] = mk(7'h7F, 0, 0, 0, 1);
        vecs[11] = mk(7'h7F, 0, 0, 0, 1);
        vecs[12] = mk(7'h00, 0, 0, 0, 1);   // restart inside message
        vecs[13] = mk("A",   0, 0, 0, 1);
        vecs[14] = mk(7'h00, 0, 0, 1, 1);
        vecs[15] = mk("B",   1, 1, 0, 1);
        vecs[16] = mk(7'h7F, 0, 0, 0, 2);
        vecs[17] = mk("x",   0, 0, 1, 2);   // stray char while idle
        vecs[18] = mk(7'h7F, 0, 0, 0, 2);

        reset         = 1'b1;
        bus.rx        = CON_IDLE_SYM;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_char",  bus.out_char, 0);
        chk("rst_out_last",  bus.out_last, 0);
        chk("rst_msg_count", bus.msg_count, 0);
        chk("rst_ovf",       bus.ovf, 0);
        chk("rst_frm_err",   bus.frm_err, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].sb_en) expect_char(vecs[i].rx, vecs[i].sb_last);
            cyc(vecs[i].rx, 1'b1);
            chk($sformatf("vec%0d_frm_err", i), bus.frm_err, vecs[i].exp_frm);
            chk($sformatf("vec%0d_msg_count", i), bus.msg_count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_ovf", i), bus.ovf, 0);
        end
        drain();

        // Overflow: 20-char message with the consumer stalled.
        cyc(CON_START_SYM, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expect_char(7'(7'h61 + i), 1'b0);
            cyc(7'(7'h61 + i), 1'b0);
        end
        cyc(CON_IDLE_SYM, 1'b0);
        chk("ovf_set", bus.ovf, 1);
        chk("ovf_msg_count", bus.msg_count, 3);
        chk("ovf_out_valid", bus.out_valid, 1);
        drain();
        chk("ovf_sticky", bus.ovf, 1);

        // Reset clears sticky overflow and the counter.
        reset = 1'b1;
        cyc(CON_IDLE_SYM, 1'b0);
        reset = 1'b0;
        chk("rst2_ovf", bus.ovf, 0);
        chk("rst2_msg_count", bus.msg_count, 0);

        // Full FIFO with push and pop on the same edge: 17 chars through 16 slots.
        cyc(CON_START_SYM, 1'b0);
        for (int i = 0; i < 17; i++) begin
            expect_char(7'(7'h41 + i), (i == 16));
            cyc(7'(7'h41 + i), 1'b0);
        end
        chk("full_no_ovf", bus.ovf, 0);
        cyc(CON_IDLE_SYM, 1'b1);
        chk("pp_ovf", bus.ovf, 0);
        chk("pp_msg_count", bus.msg_count, 1);
        bus.out_ready = 1'b0;
        drain();
        chk("pp_ovf_after", bus.ovf, 0);

        // Reset in the middle of a message discards stage and FIFO.
        cyc(CON_START_SYM, 1'b0);
        cyc("A", 1'b0);
        cyc("B", 1'b0);
        chk("mid_out_valid", bus.out_valid, 1);
        reset = 1'b1;
        cyc(CON_IDLE_SYM, 1'b0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_char",  bus.out_char, 0);
        chk("mid_rst_out_last",  bus.out_last, 0);
        chk("mid_rst_msg_count", bus.msg_count, 0);
        chk("mid_rst_ovf",       bus.ovf, 0);
        chk("mid_rst_frm_err",   bus.frm_err, 0);
        reset = 1'b0;
        repeat (3) cyc(CON_IDLE_SYM, 1'b0);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_msg_count", bus.msg_count, 0);
        chk("post_rst_frm_err",   bus.frm_err, 0);
        chk("post_rst_sb_empty",  sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
